submarine_grid: RTL and testbench

Parametrised successor of the fixed 6x6 submarine game: an N x N board loaded cell by cell with ship IDs instead of hard-coded maps. Each ship tracks its own remaining-hit count, so sink detection is exact (closes BUG 001). Duplicate shots are detected and reported instead of silently ignored. Sits between the player-input front end and the score/LED logic; one shot is resolved every 2 cycles.

---
 rtl/submarine_grid.sv | 141 ++++++++++++++
 tb/tb_submarine_grid.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/submarine_grid.sv
// submarine_grid: N x N submarine board loaded cell by cell with ship IDs.
// Tracks per-ship remaining hits and a shot map; resolves one shot every 2 cycles.
module submarine_grid #(
  parameter int unsigned GRID      = 6,
  parameter int unsigned MAX_SHIPS = 7,
  parameter int unsigned CW        = $clog2(GRID),
  parameter int unsigned IW        = $clog2(MAX_SHIPS + 1),
  parameter int unsigned SCW       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           load_en,
  input  logic [CW-1:0]  load_x,
  input  logic [CW-1:0]  load_y,
  input  logic [IW-1:0]  load_id,
  input  logic           start,
  input  logic           cord_valid,
  input  logic [CW-1:0]  x,
  input  logic [CW-1:0]  y,
  output logic           busy,
  output logic           result_valid,
  output logic           hit,
  output logic           miss,
  output logic           rpt,
  output logic           invalid,
  output logic           sink,
  output logic [IW-1:0]  sink_id,
  output logic           done,
  output logic [SCW-1:0] shot_count
);
  localparam int unsigned Cells = GRID * GRID;
  localparam int unsigned AW    = $clog2(Cells);
  localparam int unsigned RW    = $clog2(Cells + 1);

  typedef enum logic [1:0] {StLoad, StPlay, StResolve, StDone} state_e;
  state_e state_q, state_d;

  logic [IW-1:0]      id_map_q [Cells];
  logic [Cells-1:0]   shot_map_q;
  logic [RW-1:0]      remain_q [MAX_SHIPS+1];
  logic [MAX_SHIPS:0] alive_q, alive_d;  // bit 0 is water and never set
  logic [CW-1:0]      sx_q, sy_q;

  logic          load_in, load_ok, shot_in, shot_seen;
  logic [AW-1:0] load_idx, shot_idx;
  logic [IW-1:0] shot_id;
  logic          r_hit, r_sink, r_done;

  always_comb begin
    load_in   = (32'(load_x) < GRID) && (32'(load_y) < GRID);
    load_idx  = load_in ? AW'(load_x) * AW'(GRID) + AW'(load_y) : '0;
    load_ok   = (state_q == StLoad) && load_en && load_in && (load_id != '0) &&
                (32'(load_id) <= MAX_SHIPS) && (id_map_q[load_idx] == '0);

    shot_in   = (32'(sx_q) < GRID) && (32'(sy_q) < GRID);
    shot_idx  = shot_in ? AW'(sx_q) * AW'(GRID) + AW'(sy_q) : '0;
    shot_id   = id_map_q[shot_idx];
    shot_seen = shot_map_q[shot_idx];
    r_hit     = shot_in && !shot_seen && (shot_id != '0);
    r_sink    = r_hit && (remain_q[shot_id] == RW'(1));

    alive_d = alive_q;
    if (load_ok) alive_d[load_id] = 1'b1;
    if ((state_q == StResolve) && r_sink) alive_d[shot_id] = 1'b0;
    r_done = r_sink && (alive_d == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (start) state_d = (alive_d == '0) ? StDone : StPlay;
      StPlay:    if (cord_valid) state_d = StResolve;
      StResolve: state_d = r_done ? StDone : StPlay;
      StDone:    state_d = StDone;
      default:   state_d = StLoad;
    endcase
  end

  assign busy = (state_q != StPlay);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= StLoad;
      for (int unsigned i = 0; i < Cells; i++) id_map_q[i] <= '0;
      for (int unsigned k = 0; k <= MAX_SHIPS; k++) remain_q[k] <= '0;
      shot_map_q   <= '0;
      alive_q      <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      result_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      rpt          <= 1'b0;
      invalid      <= 1'b0;
      sink         <= 1'b0;
      sink_id      <= '0;
      done         <= 1'b0;
      shot_count   <= '0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      // Result flags are single-cycle pulses
      result_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      rpt          <= 1'b0;
      invalid      <= 1'b0;
      sink         <= 1'b0;
      sink_id      <= '0;

      if (load_ok) begin
        id_map_q[load_idx] <= load_id;
        remain_q[load_id]  <= remain_q[load_id] + RW'(1);
      end
      if ((state_q == StLoad) && start && (alive_d == '0)) done <= 1'b1;

      if ((state_q == StPlay) && cord_valid) begin
        sx_q <= x;
        sy_q <= y;
      end

      if (state_q == StResolve) begin
        result_valid <= 1'b1;
        invalid      <= !shot_in;
        rpt          <= shot_in && shot_seen;
        miss         <= shot_in && !shot_seen && (shot_id == '0);
        hit          <= r_hit;
        sink         <= r_sink;
        sink_id      <= r_sink ? shot_id : '0;
        if (r_done) done <= 1'b1;
        if (shot_in) begin
          shot_map_q[shot_idx] <= 1'b1;
          if (shot_count != '1) shot_count <= shot_count + SCW'(1);
        end
        if (r_hit) remain_q[shot_id] <= remain_q[shot_id] - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_submarine_grid.sv
// Self-checking bench for submarine_grid: fixed vector table, hand-written corner
// sequences and randomized games checked against a board-level reference model.
module tb_submarine_grid;
  localparam int GRID = 6;

  logic       clk = 1'b0;
  logic       rst, clear, load_en, start, cord_valid;
  logic [2:0] load_x, load_y, load_id, x, y;
  logic       busy, result_valid, hit, miss, rpt, invalid, sink, done;
  logic [2:0] sink_id;
  logic [7:0] shot_count;

  int n_checks = 0;
  int n_err    = 0;

  submarine_grid #(.GRID(6), .MAX_SHIPS(7), .SCW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .load_en     (load_en),
    .load_x      (load_x),
    .load_y      (load_y),
    .load_id     (load_id),
    .start       (start),
    .cord_valid  (cord_valid),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .result_valid(result_valid),
    .hit         (hit),
    .miss        (miss),
    .rpt         (rpt),
    .invalid     (invalid),
    .sink        (sink),
    .sink_id     (sink_id),
    .done        (done),
    .shot_count  (shot_count)
  );

  always #5 clk = ~clk;

  // Reference model: the board as a 2-D array of IDs plus a shot mask.
  int m_id   [GRID][GRID];
  bit m_shot [GRID][GRID];
  int m_count;
  bit m_done;

  typedef struct {
    bit          fresh;
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  // Packed view: {busy, rv, hit, miss, rpt, invalid, sink, sink_id[2:0], done, count[7:0]}
  function automatic logic [31:0] ev(int b, int rv, int h, int mi, int r, int inv, int s,
                                     int sid, int d, int cnt);
    return {13'b0, 1'(b), 1'(rv), 1'(h), 1'(mi), 1'(r), 1'(inv), 1'(s), 3'(sid), 1'(d),
            8'(cnt)};
  endfunction

  function automatic logic [31:0] dut_out();
    return {13'b0, busy, result_valid, hit, miss, rpt, invalid, sink, sink_id, done,
            shot_count};
  endfunction

  function automatic void m_clear();
    foreach (m_id[i, j]) begin
      m_id[i][j]   = 0;
      m_shot[i][j] = 1'b0;
    end
    m_count = 0;
    m_done  = 1'b0;
  endfunction

  function automatic void m_load(int lx, int ly, int lid);
    if (lx < GRID && ly < GRID && lid >= 1 && lid <= 7 && m_id[lx][ly] == 0) m_id[lx][ly] = lid;
  endfunction

  function automatic bit m_afloat(int k);
    foreach (m_id[i, j]) if (m_id[i][j] == k && !m_shot[i][j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fleet();
    int n = 0;
    for (int k = 1; k <= 7; k++) if (m_afloat(k)) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_shoot(int sx, int sy);
    int h = 0, mi = 0, r = 0, inv = 0, s = 0, sid = 0;
    if (sx >= GRID || sy >= GRID) begin
      inv = 1;
    end else begin
      if (m_count < 255) m_count++;
      if (m_shot[sx][sy]) begin
        r = 1;
      end else begin
        m_shot[sx][sy] = 1'b1;
        if (m_id[sx][sy] == 0) begin
          mi = 1;
        end else begin
          h = 1;
          if (!m_afloat(m_id[sx][sy])) begin
            s   = 1;
            sid = m_id[sx][sy];
            if (m_fleet() == 0) m_done = 1'b1;
          end
        end
      end
    end
    return ev(int'(m_done), 1, h, mi, r, inv, s, sid, int'(m_done), m_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h want %05h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
  endtask

  task automatic load_cell(input int lx, input int ly, input int lid);
    load_en = 1'b1;
    load_x  = 3'(lx);
    load_y  = 3'(ly);
    load_id = 3'(lid);
    tick();
    load_en = 1'b0;
    m_load(lx, ly, lid);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (m_fleet() == 0) m_done = 1'b1;
  endtask

  task automatic std_board();
    do_clear();
    load_cell(0, 0, 1);
    load_cell(0, 1, 1);
    load_cell(0, 2, 1);
    load_cell(3, 4, 2);
    do_start();
  endtask

  task automatic shoot(input int sx, input int sy, input string name,
                       input bit use_tbl, input logic [31:0] tbl_exp);
    int n = 0;
    logic [31:0] e;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: busy=1 after %0d cycles, want busy=0", name, n);
      return;
    end
    cord_valid = 1'b1;
    x = 3'(sx);
    y = 3'(sy);
    tick();
    cord_valid = 1'b0;
    check({name, " pending"}, {30'b0, busy, result_valid}, 32'b10);
    tick();
    e = m_shoot(sx, sy);
    if (use_tbl) e = tbl_exp;
    check(name, dut_out(), e);
  endtask

  task automatic idle_after_done(input string name);
    cord_valid = 1'b1;
    x = 3'd5;
    y = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check(name, {21'b0, busy, result_valid, done, shot_count},
            {21'b0, 1'b1, 1'b0, 1'b1, 8'(m_count)});
    end
    cord_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [8];
    int nl, sx, sy;
    rst = 1'b1; clear = 1'b0; load_en = 1'b0; start = 1'b0; cord_valid = 1'b0;
    load_x = '0; load_y = '0; load_id = '0; x = '0; y = '0;
    m_clear();

    tbl[0] = '{1'b1, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 1)};
    tbl[1] = '{1'b0, 0, 2, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 2)};
    tbl[2] = '{1'b0, 0, 1, ev(0, 1, 1, 0, 0, 0, 1, 1, 0, 3)};
    tbl[3] = '{1'b0, 3, 4, ev(1, 1, 1, 0, 0, 0, 1, 2, 1, 4)};
    tbl[4] = '{1'b1, 5, 5, ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 1)};
    tbl[5] = '{1'b0, 5, 5, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 2)};
    tbl[6] = '{1'b0, 6, 0, ev(0, 1, 0, 0, 0, 1, 0, 0, 0, 2)};
    tbl[7] = '{1'b0, 2, 7, ev(0, 1, 0, 0, 0, 1, 0, 0, 0, 2)};

    tick();
    tick();
    check("reset", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    check("post reset", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].fresh) std_board();
      shoot(tbl[i].x, tbl[i].y, $sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
      if (tbl[i].exp[8]) idle_after_done($sformatf("tbl%0d idle", i));
    end

    // First write to a cell wins
    do_clear();
    load_cell(1, 1, 3);
    load_cell(1, 1, 4);
    do_start();
    shoot(1, 1, "dup load", 1'b1, ev(1, 1, 1, 0, 0, 0, 1, 3, 1, 1));

    do_clear();
    do_start();
    check("empty start", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // cord_valid held high: accept every other cycle, 2-cycle latency
    std_board();
    cord_valid = 1'b1;
    x = 3'd5;
    y = 3'd5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 1) check($sformatf("stream%0d", i), {30'b0, busy, result_valid}, 32'b10);
      else check($sformatf("stream%0d", i), dut_out(), m_shoot(5, 5));
    end
    cord_valid = 1'b0;

    // clear while the shot is being resolved
    std_board();
    cord_valid = 1'b1;
    x = 3'd0;
    y = 3'd0;
    tick();
    cord_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    check("clear in resolve", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("load after clear", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cord_valid = 1'b1;
    tick();
    tick();
    cord_valid = 1'b0;
    check("shot ignored in load", dut_out(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    std_board();
    shoot(0, 0, "replay", 1'b1, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 1));

    // shot_count saturation
    do_clear();
    load_cell(0, 0, 1);
    do_start();
    for (int i = 0; i < 258; i++) shoot(5, 5, $sformatf("sat%0d", i), 1'b0, '0);

    // Randomized games
    for (int r = 0; r < 6; r++) begin
      do_clear();
      nl = int'($urandom_range(0, 14));
      for (int k = 0; k < nl; k++)
        load_cell(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
      do_start();
      if (m_done) check($sformatf("rand%0d empty", r), dut_out(),
                        ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 120 && !m_done; k++) begin
        sx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
        sy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
        shoot(sx, sy, $sformatf("rand%0d shot%0d", r, k), 1'b0, '0);
      end
      if (m_done) idle_after_done($sformatf("rand%0d idle", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
